// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if
// Purpose : groups the three handshake channels of the instruction-fetch
//           queue: PC stage -> fetch, fetch <-> instruction memory, and
//           fetch -> decode.
// Handshake semantics (all channels): a transfer happens on a rising clock
//   edge where both valid and ready are high. The offering side holds its
//   valid high and its payload stable until that transfer happens. The
//   memory response channel has no ready: the fetch queue always takes a
//   response, because credit is reserved when the request is issued.
// Signals :
//   pc_valid/pc_addr/pc_ready                  PC stage offers a word address
//   imem_req_valid/imem_req_addr/imem_req_ready request to instruction memory
//   imem_resp_valid/imem_resp_data             in-order response word
//   inst_valid/inst_data/inst_pc/inst_ready    head entry to decode
// Modports: slave = fetch queue view, master = environment view.
// ---------------------------------------------------------------------------
interface if_fetch_queue_if;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        pc_ready;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport slave (
    input  pc_valid, pc_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
           inst_ready,
    output pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_data,
           inst_pc
  );

  modport master (
    output pc_valid, pc_addr, imem_req_ready, imem_resp_valid, imem_resp_data,
           inst_ready,
    input  pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_data,
           inst_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Purpose : instruction-fetch stage behind the PC. Accepts PCs, issues them
//           to instruction memory, remembers the PC of every in-flight
//           request, queues returned words with their PC and presents them
//           to decode. A redirect flush empties the queue and arranges for
//           every stale in-flight response to be discarded on return.
// Ports   :
//   clk    in   clock, all state updates on posedge
//   clr    in   asynchronous active-high reset
//   flush  in   redirect: discard queued and in-flight fetches
//   busy   out  any entry queued, in flight, or still to be dropped
//   bus    slave modport of if_fetch_queue_if (PC, memory, decode channels)
// Parameters: DEPTH (power of 2, 2..16) bounds queued + in-flight entries.
// Optional  : define IF_FETCH_BYPASS_EN to forward a response straight to
//             decode in its arrival cycle when the queue is empty.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  output logic             busy,
  if_fetch_queue_if.slave  bus
);

  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fifo_pc   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [31:0]      tag_q     [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CNT_W-1:0] count, inflight, drop;
  logic [CNT_W:0]   occupancy;

  logic space, req_valid, req_fire;
  logic resp_counted, resp_capture;
  logic fifo_has, byp_valid, byp_take, push, pop;

  // Credit covers both queued words and words still owed by memory, so a
  // returning response always has a FIFO slot waiting for it.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign space     = occupancy < (CNT_W+1)'(DEPTH);

  assign req_valid          = bus.pc_valid & space & ~flush & ~clr;
  assign req_fire           = req_valid & bus.imem_req_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_addr;
  assign bus.pc_ready       = req_fire;

  // A response is only counted if something is owed; a stray one is ignored.
  assign resp_counted = bus.imem_resp_valid & (inflight != '0);
  assign resp_capture = resp_counted & (drop == '0) & ~flush;

  assign fifo_has = (count != '0);

`ifdef IF_FETCH_BYPASS_EN
  assign byp_valid = resp_capture & ~fifo_has;
`else
  assign byp_valid = 1'b0;
`endif
  // A bypassed word that decode takes immediately never enters the FIFO.
  assign byp_take = byp_valid & bus.inst_ready;
  assign push     = resp_capture & ~byp_take;
  assign pop      = fifo_has & bus.inst_ready & ~flush;

  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst_data  = '0;
    bus.inst_pc    = '0;
    if (fifo_has) begin
      bus.inst_valid = 1'b1;
      bus.inst_data  = fifo_data[rd_ptr];
      bus.inst_pc    = fifo_pc[rd_ptr];
    end else if (byp_valid) begin
      bus.inst_valid = 1'b1;
      bus.inst_data  = bus.imem_resp_data;
      bus.inst_pc    = tag_q[tag_rd];
    end
  end

  assign busy = fifo_has | (inflight != '0) | (drop != '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      count    <= '0;
      // Everything still owed after this edge is stale and must be dropped.
      inflight <= inflight - CNT_W'(resp_counted);
      drop     <= inflight - CNT_W'(resp_counted);
    end else begin
      if (req_fire)     tag_wr <= tag_wr + 1'b1;
      if (resp_capture) tag_rd <= tag_rd + 1'b1;
      if (push)         wr_ptr <= wr_ptr + 1'b1;
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_counted);
      if (resp_counted && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_wr] <= bus.pc_addr;
    if (push) begin
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
      fifo_data[wr_ptr] <= bus.imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  a_no_stray_resp: assert property (@(posedge clk) disable iff (clr)
    bus.imem_resp_valid |-> (inflight != '0));
  a_inflight_bound: assert property (@(posedge clk) disable iff (clr)
    (inflight <= CNT_W'(DEPTH)) && (drop <= inflight));
  a_count_bound: assert property (@(posedge clk) disable iff (clr)
    occupancy <= (CNT_W+1)'(DEPTH));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Directed bench for if_fetch_queue (DEPTH=4). Stimulus tasks push the
// expected {pc,data} of every fetch that should reach decode into exp_q; a
// monitor pops and compares whenever decode consumes an entry. A small
// memory model answers requests in order with a one-cycle latency and can
// be held off to keep responses in flight.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

  logic clk = 1'b0;
  logic clr;
  logic flush;
  logic busy;

  if_fetch_queue_if bus();

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;

  // ---------------- memory model state ----------------
  logic [31:0] pend_q [$];
  bit          resp_en   = 1'b0;
  int          acc_count = 0;
  bit          fire_s    = 1'b0;
  logic [31:0] addr_s    = '0;
  bit          lat_chk   = 1'b0;
  bit          prev_resp = 1'b0;
  logic [31:0] prev_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0000_BEEF;
      32'h40:  return 32'h0000_1234;
      default: return 32'hA0 + a;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: samples the request handshake mid-cycle, answers in order.
  always @(negedge clk) begin
    fire_s = bus.imem_req_valid & bus.imem_req_ready;
    addr_s = bus.imem_req_addr;
  end

  always @(posedge clk) begin
    if (clr) pend_q.delete();
    else if (fire_s) begin
      pend_q.push_back(addr_s);
      acc_count++;
    end
    #1;
    if (resp_en && pend_q.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!clr) begin
`ifndef IF_FETCH_BYPASS_EN
      if (lat_chk && prev_resp) begin
        check("latency_valid", 64'(bus.inst_valid), 64'd1);
        check("latency_data", 64'(bus.inst_data), 64'(prev_data));
      end
`endif
      prev_resp = bus.imem_resp_valid;
      prev_data = bus.imem_resp_data;
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual pc=%h data=%h required=none",
                   bus.inst_pc, bus.inst_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("inst_out", {bus.inst_pc, bus.inst_data}, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_pc(input logic [31:0] a, input logic [31:0] d,
                          input bit exp_out);
    int n;
    n = 0;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = a;
    if (exp_out) exp_q.push_back({a, d});
    @(negedge clk);
    while (!bus.pc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pc_ready) begin
      checks++;
      failures++;
      $display("FAIL pc_accept_timeout actual=0 required=1 pc=%h", a);
    end
    @(posedge clk);
    #1;
    bus.pc_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    clr = 1'b0;
    flush = 1'b0;
    bus.pc_valid = 1'b0;
    bus.pc_addr = '0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("reset_inst_data", 64'(bus.inst_data), 64'd0);
    check("reset_inst_pc", 64'(bus.inst_pc), 64'd0);
    check("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("reset_pc_ready", 64'(bus.pc_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back fetch, no stall.
    bus.inst_ready = 1'b1;
    @(negedge clk);
    resp_en = 1'b1;
    lat_chk = 1'b1;
    @(posedge clk);
    #1;
    issue_pc(32'h0, 32'hA0, 1'b1);
    issue_pc(32'h1, 32'hA1, 1'b1);
    issue_pc(32'h2, 32'hA2, 1'b1);
    issue_pc(32'h3, 32'hA3, 1'b1);
    wait_drain(20);
    repeat (2) @(posedge clk);
    #1;
    lat_chk = 1'b0;

    // Credit full: four accepted, then held off until decode pops one.
    bus.inst_ready = 1'b0;
    acc_count = 0;
    issue_pc(32'h8, 32'hA8, 1'b1);
    issue_pc(32'h9, 32'hA9, 1'b1);
    issue_pc(32'hA, 32'hAA, 1'b1);
    issue_pc(32'hB, 32'hAB, 1'b1);
    check("credit_accepted", 64'(acc_count), 64'd4);
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hC;
    exp_q.push_back({32'hC, 32'hAC});
    repeat (5) begin
      @(negedge clk);
      check("full_pc_ready", 64'(bus.pc_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    check("pc_ready_after_pop", 64'(bus.pc_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.pc_valid = 1'b0;
    check("credit_accepted_after_pop", 64'(acc_count), 64'd5);
    bus.inst_ready = 1'b1;
    wait_drain(20);

    // Flush with two responses in flight.
    @(negedge clk);
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    issue_pc(32'h20, 32'h0, 1'b0);
    issue_pc(32'h21, 32'h0, 1'b0);
    @(negedge clk);
    check("pre_flush_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_busy", 64'(busy), 64'd1);
    check("post_flush_inst_valid", 64'(bus.inst_valid), 64'd0);
    resp_en = 1'b1;
    wait_idle(20);
    @(posedge clk);
    #1;
    issue_pc(32'h40, 32'h1234, 1'b1);
    wait_drain(20);

    // Flush in the same cycle as the only outstanding response.
    @(negedge clk);
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    issue_pc(32'h30, 32'h0, 1'b0);
    @(negedge clk);
    resp_en = 1'b1;
    @(posedge clk);
    #2;
    check("sim_resp_present", 64'(bus.imem_resp_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("sim_flush_busy", 64'(busy), 64'd0);
    check("sim_flush_inst_valid", 64'(bus.inst_valid), 64'd0);

    // Async reset with three entries queued.
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
    issue_pc(32'h50, 32'h0, 1'b0);
    issue_pc(32'h51, 32'h0, 1'b0);
    issue_pc(32'h52, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_inst_valid", 64'(bus.inst_valid), 64'd1);
    check("pre_reset_inst_pc", 64'(bus.inst_pc), 64'h50);
    #2;
    clr = 1'b1;
    #1;
    check("async_reset_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("post_reset_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("post_reset_busy", 64'(busy), 64'd0);

`ifdef IF_FETCH_BYPASS_EN
    // Bypass: response forwarded to decode in its arrival cycle.
    bus.inst_ready = 1'b1;
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    issue_pc(32'h10, 32'hBEEF, 1'b1);
    @(negedge clk);
    resp_en = 1'b1;
    @(posedge clk);
    #2;
    check("bypass_valid", 64'(bus.inst_valid), 64'd1);
    check("bypass_out", {bus.inst_pc, bus.inst_data}, {32'h10, 32'hBEEF});
    @(posedge clk);
    @(negedge clk);
    check("bypass_after_valid", 64'(bus.inst_valid), 64'd0);
    check("bypass_after_busy", 64'(busy), 64'd0);
`endif

    bus.inst_ready = 1'b1;
    wait_drain(20);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
